// File: rtl/demux_pkg.sv
// demux_pkg: shared types and constants for the demultiplexer_stream block.
//   NUM_CH     - number of output channels
//   CNT_W      - width of the accepted-word counter
//   ch_sel_t   - destination select as carried on the input port
//   ch_idx_t   - channel index used when decoding the select
//   sel_decode - one-hot decode of a channel index
package demux_pkg;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;

  typedef logic [1:0]                  ch_sel_t;
  typedef logic [$clog2(NUM_CH)-1:0]   ch_idx_t;

  function automatic logic [NUM_CH-1:0] sel_decode(input ch_idx_t sel);
    logic [NUM_CH-1:0] onehot;
    onehot      = '0;
    onehot[sel] = 1'b1;
    return onehot;
  endfunction

endpackage

// File: rtl/demux_chan_fifo.sv
// demux_chan_fifo: per-channel synchronous FIFO.
//   clk, rst   - clock, synchronous active-high reset (empties the FIFO)
//   push       - write push_data this cycle (ignored when full)
//   push_data  - word to write
//   pop        - remove the head word this cycle (ignored when empty)
//   head       - current head word (meaningful only when not empty)
//   full       - count == DEPTH
//   empty      - count == 0
//   count      - occupancy, 0..DEPTH
// Storage is not reset; only pointers and occupancy are.
module demux_chan_fifo
  import demux_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/demultiplexer_stream.sv
// demultiplexer_stream: registered 1-to-4 stream demultiplexer.
//   clk, rst          - clock, synchronous active-high reset
//   in_data, in_sel   - word and destination channel (00->ch1 .. 11->ch4)
//   in_valid/in_ready - input handshake; in_ready depends only on in_sel
//                       and registered occupancy
//   output1..output4  - channel head words; hold last delivered word when empty
//   out_valid[k]      - channel k+1 has a word
//   out_ready[k]      - consumer takes channel k+1 head word
//   xfer_cnt          - accepted words, modulo 256
module demultiplexer_stream
  import demux_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [1:0]         in_sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   output1,
  output logic [WIDTH-1:0]   output2,
  output logic [WIDTH-1:0]   output3,
  output logic [WIDTH-1:0]   output4,
  output logic [3:0]         out_valid,
  input  logic [3:0]         out_ready,
  output logic [7:0]         xfer_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;

  ch_idx_t           sel_idx;
  logic              accept;
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] empty;
  logic [WIDTH-1:0]  head     [NUM_CH];
  logic [WIDTH-1:0]  hold     [NUM_CH];
  logic [WIDTH-1:0]  out_data [NUM_CH];
  logic [CW-1:0]     count    [NUM_CH];

  assign sel_idx  = ch_idx_t'(in_sel);
  // A full channel refuses even if it pops this cycle; keeps in_ready off out_ready.
  assign in_ready = !rst && !full[sel_idx];
  assign accept   = in_valid && in_ready;
  assign push     = sel_decode(sel_idx) & {NUM_CH{accept}};

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign out_valid[k] = (count[k] != '0);
    assign pop[k]       = out_valid[k] && out_ready[k];
    // Empty channel shows the last word it delivered.
    assign out_data[k]  = empty[k] ? hold[k] : head[k];

    demux_chan_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push[k]),
      .push_data (in_data),
      .pop       (pop[k]),
      .head      (head[k]),
      .full      (full[k]),
      .empty     (empty[k]),
      .count     (count[k])
    );
  end

  assign output1 = out_data[0];
  assign output2 = out_data[1];
  assign output3 = out_data[2];
  assign output4 = out_data[3];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_CH; k++) hold[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (pop[k]) hold[k] <= head[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)         xfer_cnt <= '0;
    else if (accept) xfer_cnt <= xfer_cnt + 1'b1;
  end

endmodule

// File: tb/tb_demultiplexer_stream.sv
// Self-checking bench for demultiplexer_stream: per-channel queue model,
// negedge compare of every output, directed scenarios plus random traffic.
module tb_demultiplexer_stream;

  localparam int WIDTH = 4;
  localparam int DEPTH = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in_data;
  logic [1:0] in_sel;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] output1, output2, output3, output4;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [7:0] xfer_cnt;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  demultiplexer_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .output1   (output1),
    .output2   (output2),
    .output3   (output3),
    .output4   (output4),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .xfer_cnt  (xfer_cnt)
  );

  logic [3:0] dout [4];
  assign dout[0] = output1;
  assign dout[1] = output2;
  assign dout[2] = output3;
  assign dout[3] = output4;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: one queue per channel, last delivered word, counter.
  logic [3:0] mq [4][$];
  logic [3:0] mlast [4];
  int         mcnt = 0;
  bit         macc = 1'b0;
  logic       pv = 1'b0;
  logic [1:0] psel = '0;
  logic [3:0] pdata = '0;
  bit         pacc = 1'b0;

  always @(posedge clk) begin
    // Upstream rule: a pending word may be withdrawn but not altered.
    if (pv && !pacc && in_valid)
      assert (in_sel == psel && in_data == pdata)
        else $error("bench drove unstable pending input");
    macc = !rst && in_valid && (mq[in_sel].size() < DEPTH);
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        mq[k].delete();
        mlast[k] = '0;
      end
      mcnt = 0;
    end else begin
      for (int k = 0; k < 4; k++)
        if (mq[k].size() != 0 && out_ready[k]) mlast[k] = mq[k].pop_front();
      if (macc) begin
        mq[in_sel].push_back(in_data);
        mcnt = (mcnt + 1) % 256;
      end
    end
    pv = in_valid; psel = in_sel; pdata = in_data; pacc = macc;
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("out_valid[%0d]", k), 32'(out_valid[k]), 32'(mq[k].size() != 0));
        chk($sformatf("output%0d", k + 1), 32'(dout[k]),
            32'((mq[k].size() != 0) ? mq[k][0] : mlast[k]));
      end
      chk("in_ready", 32'(in_ready), 32'(!rst && (mq[in_sel].size() < DEPTH)));
      chk("xfer_cnt", 32'(xfer_cnt), 32'(mcnt));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic push_word(input logic [1:0] sel, input logic [3:0] data);
    in_valid = 1'b1; in_sel = sel; in_data = data;
  endtask

  initial begin
    rst = 1'b1; in_data = '0; in_sel = '0; in_valid = 1'b0; out_ready = '0;

    // Reset
    step();
    cmp_en = 1'b1;
    step();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    settle();
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_out_valid", 32'(out_valid), 32'h0);
    chk("post_rst_xfer", 32'(xfer_cnt), 32'd0);
    chk("post_rst_output1", 32'(output1), 32'd0);

    // Route A->ch1, 5->ch4
    out_ready = 4'hF;
    push_word(2'd0, 4'hA);
    step();
    push_word(2'd3, 4'h5);
    settle();
    chk("route_valid1", 32'(out_valid), 32'b0001);
    chk("route_out1", 32'(output1), 32'hA);
    step();
    in_valid = 1'b0;
    settle();
    chk("route_valid4", 32'(out_valid), 32'b1000);
    chk("route_out4", 32'(output4), 32'h5);
    chk("route_hold1", 32'(output1), 32'hA);
    chk("route_xfer", 32'(xfer_cnt), 32'd2);

    // Back-pressure on ch2
    out_ready = 4'b1101;
    push_word(2'd1, 4'h1); step();
    push_word(2'd1, 4'h2); step();
    push_word(2'd1, 4'h3);
    settle();
    chk("bp_blocked", 32'(in_ready), 32'd0);
    step();
    chk("bp_still_blocked", 32'(in_ready), 32'd0);
    chk("bp_head1", 32'(output2), 32'h1);
    out_ready = 4'hF;
    settle();
    chk("bp_ready_no_bypass", 32'(in_ready), 32'd0);
    step();
    chk("bp_head2", 32'(output2), 32'h2);
    chk("bp_unblocked", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    settle();
    chk("bp_head3", 32'(output2), 32'h3);
    step();
    chk("bp_drained", 32'(out_valid), 32'h0);
    chk("bp_hold", 32'(output2), 32'h3);

    // Isolation: ch2 full and stalled, ch3 keeps flowing
    out_ready = 4'b1101;
    push_word(2'd1, 4'h4); step();
    push_word(2'd1, 4'h5); step();
    push_word(2'd1, 4'h6);
    settle();
    chk("iso_blocked", 32'(in_ready), 32'd0);
    step();
    in_valid = 1'b0;
    step();
    push_word(2'd2, 4'h7);
    settle();
    chk("iso_ch3_ready", 32'(in_ready), 32'd1);
    step();
    push_word(2'd1, 4'h6);
    settle();
    chk("iso_blocked_again", 32'(in_ready), 32'd0);
    chk("iso_out3_7", 32'(output3), 32'h7);
    step();
    in_valid = 1'b0;
    step();
    push_word(2'd2, 4'h8);
    step();
    in_valid = 1'b0;
    settle();
    chk("iso_out3_8", 32'(output3), 32'h8);
    chk("iso_ch2_head", 32'(output2), 32'h4);
    chk("iso_ch2_valid", 32'(out_valid[1]), 32'd1);
    out_ready = 4'hF;
    step(); step(); step();

    // Simultaneous push/pop on ch1
    out_ready = 4'b1110;
    push_word(2'd0, 4'h9);
    step();
    push_word(2'd0, 4'hC);
    out_ready = 4'hF;
    settle();
    chk("sim_head9", 32'(output1), 32'h9);
    chk("sim_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    settle();
    chk("sim_headC", 32'(output1), 32'hC);
    chk("sim_valid", 32'(out_valid[0]), 32'd1);
    step();
    chk("sim_empty", 32'(out_valid[0]), 32'd0);
    chk("sim_holdC", 32'(output1), 32'hC);

    // Counter wrap from a fresh reset
    rst = 1'b1; step(); rst = 1'b0;
    out_ready = 4'hF;
    for (int i = 0; i < 255; i++) begin
      push_word(2'(i % 4), 4'(i));
      step();
    end
    chk("wrap_255", 32'(xfer_cnt), 32'd255);
    step();
    in_valid = 1'b0;
    settle();
    chk("wrap_0", 32'(xfer_cnt), 32'd0);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      if (!(in_valid && !macc)) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_sel   = 2'($urandom);
        in_data  = 4'($urandom);
      end
      out_ready = (i < 750) ? 4'($urandom) : 4'($urandom | $urandom);
      step();
    end
    in_valid = 1'b0;
    out_ready = 4'hF;
    step(); step(); step();

    // Reset mid-operation
    out_ready = 4'h0;
    for (int i = 0; i < 6; i++) begin
      push_word(2'(i % 4), 4'(i + 1));
      step();
    end
    in_valid = 1'b0;
    settle();
    chk("mid_full_valid", 32'(out_valid), 32'hF);
    rst = 1'b1;
    step();
    rst = 1'b0;
    settle();
    chk("mid_out_valid", 32'(out_valid), 32'h0);
    chk("mid_output1", 32'(output1), 32'd0);
    chk("mid_output2", 32'(output2), 32'd0);
    chk("mid_output3", 32'(output3), 32'd0);
    chk("mid_output4", 32'(output4), 32'd0);
    chk("mid_xfer", 32'(xfer_cnt), 32'd0);
    chk("mid_in_ready", 32'(in_ready), 32'd1);
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
